// File: rtl/note_sequencer_pkg.sv
// Shared types, note divisor table and octave helpers for the note sequencer.
package note_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_e;

  localparam logic [3:0]  NOTE_REST  = 4'd15;
  localparam logic [3:0]  NOTE_MAX   = 4'd12;  // 13..15 are all rests
  localparam logic [1:0]  OCT_UP     = 2'b10;
  localparam logic [1:0]  OCT_DN     = 2'b01;
  localparam logic [23:0] TERM_RESET = 24'd631;

  localparam logic [9:0] DIVIS [13] = '{
    10'd631, 10'd596, 10'd562, 10'd531, 10'd501, 10'd473, 10'd446,
    10'd421, 10'd398, 10'd375, 10'd354, 10'd334, 10'd316
  };

  // Pattern byte i lives at bits [8*i +: 8]; a build can swap in its own tune via PATTERN.
  localparam logic [127:0] DEFAULT_PATTERN = 128'h0340_5070_90B0_C0F0_C1B0_9070_5040_2000;

  function automatic logic is_rest(input logic [3:0] note);
    return note > NOTE_MAX;
  endfunction

  // Divider terminal value for a note/octave pair; rests never reach the term register.
  function automatic logic [23:0] note_term(input logic [3:0] note, input logic [1:0] oct);
    logic [23:0] base;
    base = TERM_RESET;
    if (note <= NOTE_MAX) base = {14'd0, DIVIS[note]};
    case (oct)
      OCT_UP:  return base >> 1;
      OCT_DN:  return base << 1;
      default: return base;
    endcase
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the button front end and the sequencer.
interface note_sequencer_if;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [23:0] term;
  logic        term_upd;
  logic        gate;
  logic        busy;
  logic [3:0]  step;
  logic        done;

  modport master (output start, stop, loop_en,
                  input  term, term_upd, gate, busy, step, done);
  modport slave  (input  start, stop, loop_en,
                  output term, term_upd, gate, busy, step, done);
endinterface

// File: rtl/note_sequencer_pattern_rom.sv
// Case-based pattern ROM with a registered read port (data follows addr by one cycle).
module note_sequencer_pattern_rom
  import note_sequencer_pkg::*;
#(
  parameter int             STEPS   = 16,
  parameter logic [127:0]   PATTERN = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic [3:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] word;
  logic [7:0] data_q;

  // Decode the step index; anything past the pattern length reads as a rest.
  always_comb begin
    word = {NOTE_REST, 4'h0};
    case (addr_i)
      4'd0:  word = PATTERN[7:0];
      4'd1:  word = PATTERN[15:8];
      4'd2:  word = PATTERN[23:16];
      4'd3:  word = PATTERN[31:24];
      4'd4:  word = PATTERN[39:32];
      4'd5:  word = PATTERN[47:40];
      4'd6:  word = PATTERN[55:48];
      4'd7:  word = PATTERN[63:56];
      4'd8:  word = PATTERN[71:64];
      4'd9:  word = PATTERN[79:72];
      4'd10: word = PATTERN[87:80];
      4'd11: word = PATTERN[95:88];
      4'd12: word = PATTERN[103:96];
      4'd13: word = PATTERN[111:104];
      4'd14: word = PATTERN[119:112];
      4'd15: word = PATTERN[127:120];
      default: word = {NOTE_REST, 4'h0};
    endcase
    if (int'(addr_i) >= STEPS) word = {NOTE_REST, 4'h0};
  end

  // Registered read.
  always_ff @(posedge clk) data_q <= word;

  assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks the pattern ROM, times notes in beats, drives divider term and gate.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter logic [23:0]  BEAT_CYCLES = 24'd12_500_000,
  parameter logic [23:0]  GAP_CYCLES  = 24'd1_250_000,
  parameter int           STEPS       = 16,
  parameter logic [127:0] PATTERN     = DEFAULT_PATTERN
) (
  input  logic            clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [23:0] cyc_q, cyc_d;     // cycles within the current beat / gap
  logic [1:0]  beat_q, beat_d;   // beats elapsed in PLAY; split keeps 4-beat notes in 24 bits
  logic [1:0]  len_q, len_d;
  logic        rest_q, rest_d;
  logic [23:0] term_q, term_d;
  logic        upd_q, upd_d;
  logic        done_q, done_d;
  logic [7:0]  rom_data;
  logic [23:0] new_term;
  logic        last_step;

  // ROM is addressed with the next step so FETCH sees the new entry.
  note_sequencer_pattern_rom #(.STEPS(STEPS), .PATTERN(PATTERN)) u_rom (
    .clk    (clk),
    .addr_i (step_d),
    .data_o (rom_data)
  );

  assign new_term  = note_term(rom_data[7:4], rom_data[3:2]);
  assign last_step = (step_q == 4'(STEPS - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      cyc_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      rest_q  <= 1'b0;
      term_q  <= TERM_RESET;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      rest_q  <= rest_d;
      term_q  <= term_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
    end
  end

  // Next-state, duration counting and term update; stop overrides everything.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cyc_d   = cyc_q + 24'd1;
    beat_d  = beat_q;
    len_d   = len_q;
    rest_d  = rest_q;
    term_d  = term_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d  = '0;
        beat_d = '0;
        if (bus.start) begin
          state_d = FETCH;
          step_d  = '0;
        end
      end
      FETCH: begin
        len_d   = rom_data[1:0];
        rest_d  = is_rest(rom_data[7:4]);
        if (!is_rest(rom_data[7:4]) && (new_term != term_q)) begin
          term_d = new_term;
          upd_d  = 1'b1;
        end
        state_d = PLAY;
        cyc_d   = '0;
        beat_d  = '0;
      end
      PLAY: begin
        if (cyc_q == BEAT_CYCLES - 24'd1) begin
          cyc_d  = '0;
          beat_d = beat_q + 2'd1;
        end
        // Last beat is cut short by the articulation gap.
        if ((beat_q == len_q) && (cyc_q == BEAT_CYCLES - GAP_CYCLES - 24'd1)) begin
          state_d = GAP;
          cyc_d   = '0;
          beat_d  = '0;
        end
      end
      GAP: begin
        if (cyc_q == GAP_CYCLES - 24'd1) begin
          cyc_d = '0;
          if (!last_step) begin
            step_d  = step_q + 4'd1;
            state_d = FETCH;
          end else if (bus.loop_en) begin
            step_d  = '0;
            state_d = FETCH;
          end else begin
            step_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
    if (bus.stop) begin
      state_d = IDLE;
      step_d  = '0;
      cyc_d   = '0;
      beat_d  = '0;
      term_d  = term_q;
      upd_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign bus.term     = term_q;
  assign bus.term_upd = upd_q;
  assign bus.gate     = (state_q == PLAY) && !rest_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.step     = step_q;
  assign bus.done     = done_q;

endmodule
